// File: rtl/lsu_pkg.sv
// Shared definitions for the data-memory load/store unit.
//   LSU_MEM_ADDR_W : default byte-address width of the data memory.
//   lsu_size_e     : access-size encoding used on req_size.
//   lsu_state_e    : FSM state encoding of data_mem_lsu.
//   size_to_mask   : byte-write-enable pattern for a given access size.
package lsu_pkg;

  localparam int LSU_MEM_ADDR_W = 12;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } lsu_state_e;

  // Lanes are always low-justified: the memory rotates lanes for
  // misaligned addresses, so the unit never shifts the mask itself.
  function automatic logic [3:0] size_to_mask(input logic [1:0] size);
    logic [3:0] mask;
    case (size)
      SIZE_BYTE: mask = 4'b0001;
      SIZE_HALF: mask = 4'b0011;
      SIZE_WORD: mask = 4'b1111;
      default:   mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Load data extraction for the LSU (purely combinational).
//   size        : access size (byte / half / word)
//   is_unsigned : 1 = zero-extend, 0 = sign-extend
//   raw_data    : memory read word, byte 0 = byte at the access address
//   ext_data    : extended 32-bit load result
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] raw_data,
  output logic [31:0] ext_data
);

  logic sign_b;
  logic sign_h;

  assign sign_b = ~is_unsigned & raw_data[7];
  assign sign_h = ~is_unsigned & raw_data[15];

  always_comb begin
    ext_data = raw_data;
    case (size)
      SIZE_BYTE: ext_data = {{24{sign_b}}, raw_data[7:0]};
      SIZE_HALF: ext_data = {{16{sign_h}}, raw_data[15:0]};
      default:   ext_data = raw_data;
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Load/store unit between the pipeline and a single-port data memory.
//   Clk, Resetn         : clock, synchronous active-low reset
//   req_*               : request handshake (valid/ready) and fields
//   rsp_*               : response handshake, load data and error flag
//   mem_addr/wdata/wr   : memory address, store data, byte-write enables
//   mem_rdata           : memory read data, one cycle after mem_addr
//   debug_hold          : memory borrowed by the debug/init path
module data_mem_lsu
  import lsu_pkg::*;
#(
  parameter int MEM_ADDR_W = LSU_MEM_ADDR_W
) (
  input  logic                  Clk,
  input  logic                  Resetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wr,
  input  logic [31:0]           mem_rdata,
  input  logic                  debug_hold
);

  lsu_state_e            state_reg, state_next;
  logic [MEM_ADDR_W-1:0] addr_reg;
  logic [31:0]           wdata_reg;
  logic [31:0]           rdata_reg;
  logic [1:0]            size_reg;
  logic                  we_reg;
  logic                  unsigned_reg;
  logic                  err_reg;
  logic [31:0]           ext_data;
  logic                  req_illegal;
  logic                  accept;

  assign req_illegal = (req_size == SIZE_ILLEGAL) || (|req_addr[31:MEM_ADDR_W]);
  assign req_ready   = (state_reg == ST_IDLE) && !debug_hold && Resetn;
  assign accept      = req_valid && req_ready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (accept) state_next = req_illegal ? ST_RESP : ST_ACCESS;
      ST_ACCESS: if (!debug_hold) state_next = we_reg ? ST_RESP : ST_WAIT;
      // A hold during WAIT discards the read in flight; the access is
      // replayed from ACCESS once the memory is handed back.
      ST_WAIT:   state_next = debug_hold ? ST_ACCESS : ST_RESP;
      ST_RESP:   if (rsp_ready) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      state_reg    <= ST_IDLE;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      rdata_reg    <= '0;
      size_reg     <= '0;
      we_reg       <= 1'b0;
      unsigned_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        addr_reg     <= req_addr[MEM_ADDR_W-1:0];
        wdata_reg    <= req_wdata;
        size_reg     <= req_size;
        we_reg       <= req_we;
        unsigned_reg <= req_unsigned;
        err_reg      <= req_illegal;
        rdata_reg    <= '0;
      end
      if (state_reg == ST_WAIT && !debug_hold) begin
        rdata_reg <= ext_data;
      end
    end
  end

  lsu_load_extend u_load_extend (
    .size        (size_reg),
    .is_unsigned (unsigned_reg),
    .raw_data    (mem_rdata),
    .ext_data    (ext_data)
  );

  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  // Write enables are gated by debug_hold combinationally so a hold
  // raised in the ACCESS cycle itself already blocks the write.
  assign mem_wr    = (state_reg == ST_ACCESS && we_reg && !debug_hold)
                     ? size_to_mask(size_reg) : 4'b0000;

  assign rsp_valid = (state_reg == ST_RESP);
  assign rsp_err   = rsp_valid & err_reg;
  assign rsp_rdata = rsp_valid ? rdata_reg : 32'h0;

endmodule

// File: tb/tb_data_mem_lsu.sv
module tb_data_mem_lsu;

  logic        Clk = 1'b0;
  logic        Resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wr;
  logic [31:0] mem_rdata = 32'h0;
  logic        debug_hold = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int n_txn = 0;

  // memory model (rotating lanes, one-cycle read latency) and reference copy
  logic [7:0]  mem_arr [4096];
  logic [7:0]  ref_mem [4096];
  logic        fill_en = 1'b0;
  logic [11:0] fill_idx = 12'h0;
  logic [7:0]  fill_val = 8'h0;

  always #5 Clk = ~Clk;

  data_mem_lsu #(.MEM_ADDR_W(12)) dut (
    .Clk          (Clk),
    .Resetn       (Resetn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wr       (mem_wr),
    .mem_rdata    (mem_rdata),
    .debug_hold   (debug_hold)
  );

  always @(posedge Clk) begin
    if (fill_en) mem_arr[fill_idx] <= fill_val;
    for (int i = 0; i < 4; i++)
      if (mem_wr[i]) mem_arr[(int'(mem_addr) + i) % 4096] <= mem_wdata[8*i +: 8];
    for (int i = 0; i < 4; i++)
      mem_rdata[8*i +: 8] <= mem_arr[(int'(mem_addr) + i) % 4096];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One request through the unit; expectations come from ref_mem and the
  // size/extension rules, outputs are returned for literal pinning.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int hold_at, input int hold_len, input int stall,
                        output logic [31:0] o_rdata, output logic o_err, output int o_lat,
                        output logic [3:0] o_mask, output logic [11:0] o_maddr,
                        output logic [31:0] o_wdata);
    logic        exp_err;
    logic [3:0]  exp_mask;
    logic [31:0] exp_rdata, raw;
    int          exp_lat, nbytes, wr_cnt, rcount, lat;
    logic        got, seen, done;
    logic [31:0] first_rdata;
    logic        first_err;

    exp_err  = (size == 2'b11) || (addr[31:12] != 20'h0);
    nbytes   = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    exp_mask = (exp_err || !we) ? 4'b0000 : (nbytes == 1) ? 4'b0001 : (nbytes == 2) ? 4'b0011 : 4'b1111;
    exp_lat  = exp_err ? 1 : (we ? 2 : 3);
    exp_rdata = 32'h0;
    if (!exp_err && !we) begin
      raw = 32'h0;
      for (int i = 0; i < 4; i++) raw[8*i +: 8] = ref_mem[(int'(addr[11:0]) + i) % 4096];
      if (nbytes == 1)
        exp_rdata = (!uns && raw[7:0] >= 8'd128) ? 32'hFFFFFF00 + {24'h0, raw[7:0]} : {24'h0, raw[7:0]};
      else if (nbytes == 2)
        exp_rdata = (!uns && raw[15:0] >= 16'd32768) ? 32'hFFFF0000 + {16'h0, raw[15:0]} : {16'h0, raw[15:0]};
      else
        exp_rdata = raw;
    end

    o_rdata = 32'h0; o_err = 1'b0; o_lat = 0; o_mask = 4'b0; o_maddr = 12'h0; o_wdata = 32'h0;
    wr_cnt = 0; rcount = 0; lat = 0; seen = 0; done = 0;
    first_rdata = 32'h0; first_err = 1'b0;

    @(negedge Clk);
    debug_hold = 1'b0;
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    got = 0;
    for (int w = 0; w < 20 && !got; w++) begin
      #2;
      if (req_ready) got = 1;
      else @(negedge Clk);
    end
    if (!got) begin
      chk("req_ready_timeout", 32'(req_ready), 32'h1);
      req_valid = 1'b0;
      return;
    end
    @(posedge Clk);

    for (int c = 1; c <= 60 && !done; c++) begin
      @(negedge Clk);
      req_valid  = 1'b0;
      debug_hold = (hold_at > 0 && c >= hold_at && c < hold_at + hold_len);
      #2;
      if (mem_wr != 4'b0000) begin
        wr_cnt++;
        o_mask = mem_wr; o_maddr = mem_addr; o_wdata = mem_wdata;
        chk("mem_wr_mask", 32'(mem_wr), 32'(exp_mask));
        chk("mem_wr_wdata", mem_wdata, wdata);
      end
      if (debug_hold) chk("mem_wr_in_hold", 32'(mem_wr), 32'h0);
      if (!seen && !rsp_valid && !exp_err) chk("mem_addr", 32'(mem_addr), 32'(addr[11:0]));
      if (rsp_valid) begin
        chk("req_ready_in_resp", 32'(req_ready), 32'h0);
        chk("mem_wr_in_resp", 32'(mem_wr), 32'h0);
        if (!seen) begin
          seen = 1; lat = c;
          first_rdata = rsp_rdata; first_err = rsp_err;
          chk("rsp_rdata", rsp_rdata, exp_rdata);
          chk("rsp_err", 32'(rsp_err), 32'(exp_err));
          if (hold_at == 0) chk("latency", 32'(lat), 32'(exp_lat));
        end else begin
          chk("rsp_rdata_stable", rsp_rdata, first_rdata);
          chk("rsp_err_stable", 32'(rsp_err), 32'(first_err));
        end
        rcount++;
        rsp_ready = (rcount > stall);
        if (rsp_ready) begin
          done = 1;
          @(posedge Clk);
        end
      end
    end
    if (!done) chk("rsp_timeout", 32'(seen), 32'h2);

    @(negedge Clk);
    rsp_ready  = 1'b0;
    debug_hold = 1'b0;
    #2;
    chk("rsp_valid_after", 32'(rsp_valid), 32'h0);
    chk("req_ready_after", 32'(req_ready), 32'h1);
    chk("write_count", 32'(wr_cnt), (exp_mask != 4'b0000) ? 32'h1 : 32'h0);

    if (exp_mask != 4'b0000)
      for (int i = 0; i < nbytes; i++) ref_mem[(int'(addr[11:0]) + i) % 4096] = wdata[8*i +: 8];

    o_rdata = first_rdata; o_err = first_err; o_lat = lat;
    n_txn++;
    $display("txn %0d we=%0d size=%0d uns=%0d addr=%h wdata=%h hold=%0d/%0d stall=%0d -> rdata=%h err=%0d lat=%0d",
             n_txn, we, size, uns, addr, wdata, hold_at, hold_len, stall, first_rdata, first_err, lat);
  endtask

  initial begin
    logic [31:0] r_rdata, r_wdata;
    logic        r_err;
    int          r_lat;
    logic [3:0]  r_mask;
    logic [11:0] r_maddr;

    // fill memory under reset
    for (int i = 0; i < 4096; i++) begin
      @(negedge Clk);
      fill_en  = 1'b1;
      fill_idx = 12'(i);
      fill_val = 8'($urandom);
      ref_mem[i] = fill_val;
    end
    @(negedge Clk);
    fill_en = 1'b0;
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_mem_wr", 32'(mem_wr), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    @(negedge Clk);
    Resetn = 1'b1;
    #2;
    chk("idle_req_ready", 32'(req_ready), 32'h1);
    debug_hold = 1'b1;
    #1;
    chk("hold_blocks_ready", 32'(req_ready), 32'h0);
    debug_hold = 1'b0;

    // store word / load word
    do_req(1'b1, 2'b10, 1'b0, 32'h004, 32'hDEADBEEF, 0, 0, 0, r_rdata, r_err, r_lat, r_mask, r_maddr, r_wdata);
    chk("lit_store_mask", 32'(r_mask), 32'h0000000F);
    chk("lit_store_lat", 32'(r_lat), 32'd2);
    do_req(1'b0, 2'b10, 1'b0, 32'h004, 32'h0, 0, 0, 0, r_rdata, r_err, r_lat, r_mask, r_maddr, r_wdata);
    chk("lit_load_word", r_rdata, 32'hDEADBEEF);
    chk("lit_load_lat", 32'(r_lat), 32'd3);

    // byte sign/zero extension
    do_req(1'b1, 2'b00, 1'b0, 32'h007, 32'h00000080, 0, 0, 1, r_rdata, r_err, r_lat, r_mask, r_maddr, r_wdata);
    do_req(1'b0, 2'b00, 1'b0, 32'h007, 32'h0, 0, 0, 0, r_rdata, r_err, r_lat, r_mask, r_maddr, r_wdata);
    chk("lit_lb_signed", r_rdata, 32'hFFFFFF80);
    do_req(1'b0, 2'b00, 1'b1, 32'h007, 32'h0, 0, 0, 0, r_rdata, r_err, r_lat, r_mask, r_maddr, r_wdata);
    chk("lit_lb_unsigned", r_rdata, 32'h00000080);

    // misaligned half store
    do_req(1'b1, 2'b01, 1'b0, 32'h003, 32'h00001234, 0, 0, 0, r_rdata, r_err, r_lat, r_mask, r_maddr, r_wdata);
    chk("lit_sh_addr", 32'(r_maddr), 32'h003);
    chk("lit_sh_mask", 32'(r_mask), 32'h3);
    chk("lit_sh_wdata", 32'(r_wdata[15:0]), 32'h1234);

    // illegal requests
    do_req(1'b0, 2'b10, 1'b0, 32'h00001000, 32'h0, 0, 0, 0, r_rdata, r_err, r_lat, r_mask, r_maddr, r_wdata);
    chk("lit_oob_err", 32'(r_err), 32'h1);
    chk("lit_oob_lat", 32'(r_lat), 32'd1);
    do_req(1'b1, 2'b11, 1'b0, 32'h010, 32'hFFFFFFFF, 0, 0, 0, r_rdata, r_err, r_lat, r_mask, r_maddr, r_wdata);
    chk("lit_size3_err", 32'(r_err), 32'h1);
    chk("lit_size3_rdata", r_rdata, 32'h0);

    // hold during WAIT, stalled response; word @4 is now 80 AD BE 12
    do_req(1'b0, 2'b10, 1'b0, 32'h004, 32'h0, 2, 5, 3, r_rdata, r_err, r_lat, r_mask, r_maddr, r_wdata);
    chk("lit_hold_load", r_rdata, 32'h80ADBE12);
    // hold during ACCESS of a store
    do_req(1'b1, 2'b10, 1'b0, 32'h020, 32'hCAFEF00D, 1, 3, 0, r_rdata, r_err, r_lat, r_mask, r_maddr, r_wdata);
    do_req(1'b0, 2'b10, 1'b0, 32'h020, 32'h0, 0, 0, 0, r_rdata, r_err, r_lat, r_mask, r_maddr, r_wdata);
    chk("lit_hold_store", r_rdata, 32'hCAFEF00D);

    // reset in ACCESS of a store
    @(negedge Clk);
    req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h100; req_wdata = 32'h13572468;
    req_valid = 1'b1;
    #2;
    chk("rs_ready", 32'(req_ready), 32'h1);
    @(posedge Clk);
    @(negedge Clk);
    req_valid = 1'b0;
    #2;
    chk("rs_access_wr", 32'(mem_wr), 32'hF);
    for (int i = 0; i < 4; i++) ref_mem[(32'h100 + i) % 4096] = req_wdata[8*i +: 8];
    Resetn = 1'b0;
    @(negedge Clk);
    #2;
    chk("rs_mem_wr", 32'(mem_wr), 32'h0);
    chk("rs_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rs_req_ready", 32'(req_ready), 32'h0);
    chk("rs_mem_addr", 32'(mem_addr), 32'h0);
    chk("rs_mem_wdata", mem_wdata, 32'h0);
    chk("rs_rsp_rdata", rsp_rdata, 32'h0);
    chk("rs_rsp_err", 32'(rsp_err), 32'h0);
    @(negedge Clk);
    Resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      #2;
      chk("rs_no_rsp", 32'(rsp_valid), 32'h0);
      chk("rs_idle_ready", 32'(req_ready), 32'h1);
    end

    // randomized traffic, biased to a small window so loads hit stored data
    for (int t = 0; t < 150; t++) begin
      logic        we, uns;
      logic [1:0]  size;
      logic [31:0] addr, wdata;
      int          hold_at, hold_len, stall;
      we    = 1'($urandom_range(0, 1));
      uns   = 1'($urandom_range(0, 1));
      size  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      case ($urandom_range(0, 9))
        0:       addr = $urandom;
        1:       addr = 32'($urandom_range(4092, 4095));
        2, 3:    addr = 32'($urandom_range(0, 4095));
        default: addr = 32'($urandom_range(0, 31));
      endcase
      wdata = $urandom;
      if ($urandom_range(0, 4) == 0) begin
        hold_at  = $urandom_range(1, 3);
        hold_len = $urandom_range(1, 4);
      end else begin
        hold_at  = 0;
        hold_len = 0;
      end
      stall = $urandom_range(0, 2);
      do_req(we, size, uns, addr, wdata, hold_at, hold_len, stall, r_rdata, r_err, r_lat, r_mask, r_maddr, r_wdata);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_mem_lsu.md
DATA_MEM_LSU -- requirements
Module: data_mem_lsu

Interface
REQ-001 Parameter MEM_ADDR_W, default 12, byte-address width of the data memory (4096 bytes).
REQ-002 Clk  input  1  sole clock, all state updates on rising edge.
REQ-003 Resetn  input  1  reset, synchronous, active-low.
REQ-004 req_valid  input  1  pipeline presents a memory request.
REQ-005 req_ready  output  1  unit can accept a request this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-009 req_addr  input  32  byte address, any alignment.
REQ-010 req_wdata  input  32  store data, LSB-justified.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  pipeline consumes the response.
REQ-013 rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-014 rsp_err  output  1  request was illegal; no memory access was made.
REQ-015 mem_addr  output  MEM_ADDR_W  byte address to the data memory.
REQ-016 mem_wdata  output  32  store data to memory, byte 0 at mem_addr.
REQ-017 mem_wr  output  4  active-high byte-write enables; bit i writes byte at mem_addr+i.
REQ-018 mem_rdata  input  32  memory read data, byte 0 = byte at mem_addr, valid one cycle after mem_addr is presented.
REQ-019 debug_hold  input  1  memory owned by the debug/init path; unit must not access it.

Function
REQ-020 The FSM SHALL have states IDLE, ACCESS, WAIT, RESP.
REQ-021 req_ready SHALL be 1 only in IDLE with debug_hold=0 and Resetn=1.
REQ-022 On req_valid&&req_ready the unit SHALL register all request fields and leave IDLE.
REQ-023 Illegal request (req_size=11 or req_addr[31:MEM_ADDR_W]!=0) SHALL go IDLE->RESP with rsp_err=1, rsp_rdata=0, and mem_wr never asserted.
REQ-024 Legal request SHALL go IDLE->ACCESS; mem_addr SHALL equal the registered address in ACCESS and WAIT.
REQ-025 Store: mem_wr SHALL be 0001/0011/1111 for byte/half/word during ACCESS only; mem_wdata = registered wdata; ACCESS->RESP.
REQ-026 Load: mem_wr SHALL remain 0000; ACCESS->WAIT->RESP, mem_rdata captured at the end of WAIT.
REQ-027 Load extraction SHALL use mem_rdata[7:0], [15:0], or [31:0] by size, extended per req_unsigned; misaligned addresses need no special handling (memory rotates lanes).
REQ-028 Latency: load rsp_valid in the 3rd cycle after acceptance; store rsp_valid in the 2nd; error rsp_valid in the 1st.
REQ-029 rsp_valid, rsp_rdata, rsp_err SHALL be held stable in RESP until rsp_ready=1, then RESP->IDLE in that edge.
REQ-030 debug_hold=1 in ACCESS or WAIT SHALL force mem_wr=0000 and freeze the state; when it drops the unit SHALL restart at ACCESS (store re-issued, load re-read).
REQ-031 debug_hold SHALL NOT affect RESP; a pending response is still delivered.
REQ-032 No new request SHALL be accepted in the cycle RESP completes (IDLE required first).
REQ-033 mem_wr SHALL be 0000 in every state other than ACCESS.

Reset
REQ-034 Resetn=0 at a rising edge SHALL force IDLE and clear all registered request/response state, in any state, including mid-access.
REQ-035 While in reset and after it: req_ready=0 during reset, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_wr=0000, mem_addr=0, mem_wdata=0.

Structure
REQ-036 Package lsu_pkg SHALL hold the size enum, the FSM state enum and MEM_ADDR_W default.
REQ-037 Load extraction SHALL be sub-module lsu_load_extend (combinational: size, unsigned, raw data -> extended data).

Verification
REQ-038 Store word 0xDEADBEEF @0x004, then load word @0x004 -> mem_wr=1111 for 1 cycle; load rsp_rdata=0xDEADBEEF, rsp_valid in 3rd cycle.
REQ-039 Load byte signed @0x007 with memory byte 0x80 -> rsp_rdata=0xFFFFFF80; unsigned -> 0x00000080.
REQ-040 Store half 0x1234 @0x003 (misaligned) -> mem_addr=0x003, mem_wr=0011, mem_wdata[15:0]=0x1234.
REQ-041 Load @0x0000_1000 or req_size=11 -> rsp_err=1, rsp_rdata=0, mem_wr never nonzero, rsp_valid next cycle.
REQ-042 debug_hold raised during WAIT for 5 cycles, rsp_ready=0 for 3 cycles in RESP -> no mem_wr, ACCESS re-entered, response held stable until rsp_ready.
REQ-043 Resetn=0 in ACCESS of a store -> mem_wr=0000 next cycle, IDLE, all outputs 0, no response emitted.
